// File: rtl/uart_tx_fifo_bus.sv
// uart_tx_fifo_bus: buffered 8N1 UART transmitter behind an XT_BUS-style
// register slave, all on hb_clk.
// Bytes written to offset 28 are queued in a circular TX FIFO and sent
// back-to-back at a programmable bit period (offset 24).
// Optional transmit-complete interrupt: define UART_TX_IRQ_EN to build it in;
// otherwise tx_irq is tied low.
// The bus structure fields are flattened into plain ports (xt_hb_*, sel_*).

module uart_tx_fifo_bus #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        hb_clk,
    input  logic        hb_rst_n,
    input  logic [31:0] xt_hb_waddr,
    input  logic [31:0] xt_hb_raddr,
    input  logic [31:0] xt_hb_wdata,
    input  logic        sel_wen,
    input  logic        sel_ren,
    output logic [31:0] rdata,
    output logic        tx_irq,
    output logic        uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    state_t        state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;

    logic [15:0]   div;
    logic [15:0]   eff_div;
    logic [15:0]   shadow_div;
    logic [15:0]   bcnt;
    logic [7:0]    shreg;
    logic [2:0]    bidx;
    logic          bit_end;

    logic          push_req;
    logic          push_ok;
    logic          overflow_set;
    logic          pop;
    logic          div_wr;
    logic          status_rd;
    logic          tx_bit;
    logic          busy;
    logic          tx_done;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits  = ^{xt_hb_waddr[31:5], xt_hb_raddr[31:5], xt_hb_wdata[31:16]};

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign busy         = (state_q != IDLE);
    assign tx_done      = fifo_empty && !busy;
    assign bit_end      = (bcnt == 16'd0);
    assign eff_div      = (div < 16'd2) ? 16'd2 : div;

    // A push into a full FIFO is still accepted when the FSM pops that same cycle.
    assign push_req     = sel_wen && (xt_hb_waddr[4:0] == 5'd28);
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;
    assign div_wr       = sel_wen && (xt_hb_waddr[4:0] == 5'd24);
    assign status_rd    = sel_ren && (xt_hb_raddr[4:0] != 5'd24);
    assign status       = {27'b0, overflow, fifo_full, fifo_empty, busy, tx_done};

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge hb_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= xt_hb_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a dropped push in the same cycle as a status read wins.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    // Programmable bit period register.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            div <= DEFAULT_DIV;
        end else if (div_wr) begin
            div <= xt_hb_wdata[15:0];
        end
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            rdata <= 32'd0;
        end else if (sel_ren) begin
            rdata <= (xt_hb_raddr[4:0] == 5'd24) ? {16'b0, div} : status;
        end
    end

    // FSM state register.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; STOP chains straight into START when data is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bidx == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop strobe and the line level for the current bit.
    always_comb begin
        pop    = 1'b0;
        tx_bit = 1'b1;
        case (state_q)
            IDLE:    pop = !fifo_empty;
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[0];
            STOP:    pop = bit_end && !fifo_empty;
            default: tx_bit = 1'b1;
        endcase
    end

    // Bit timing and shift datapath; the divisor is frozen for the whole frame.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            bcnt       <= 16'd0;
            shadow_div <= 16'd2;
            shreg      <= 8'd0;
            bidx       <= 3'd0;
        end else if (pop) begin
            shreg      <= mem[rd_ptr];
            shadow_div <= eff_div;
            bcnt       <= eff_div - 16'd1;
            bidx       <= 3'd0;
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                bcnt <= shadow_div - 16'd1;
                if (state_q == DATA) begin
                    shreg <= shreg >> 1;
                    bidx  <= bidx + 3'd1;
                end
            end else begin
                bcnt <= bcnt - 16'd1;
            end
        end
    end

    // Serial line comes straight from a flop so it cannot glitch.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_bit;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_arm;

    // Arm on any accepted push; disarm once software reads status while the irq is up.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            irq_arm <= 1'b0;
        end else if (push_ok) begin
            irq_arm <= 1'b1;
        end else if (tx_irq && status_rd) begin
            irq_arm <= 1'b0;
        end
    end

    // Level interrupt, one cycle behind tx_done.
    always_ff @(posedge hb_clk or negedge hb_rst_n) begin
        if (!hb_rst_n) begin
            tx_irq <= 1'b0;
        end else begin
            tx_irq <= tx_done && irq_arm;
        end
    end
`else
    assign tx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_bus.sv
// tb_uart_tx_fifo_bus: self-checking bench for uart_tx_fifo_bus.
// Register accesses come from a vector table; frame timing, FIFO full/overflow,
// divisor changes and mid-frame reset use hand-written sequences.
// Honours UART_TX_IRQ_EN when it is defined for the build.

module tb_uart_tx_fifo_bus;

    typedef struct {
        bit          wr;
        logic [31:0] waddr_v;
        logic [31:0] wdata_v;
        logic [31:0] raddr_v;
        logic [31:0] exp_v;
        string       name;
    } vec_t;

`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] IRQ_EN = 32'd1;
`else
    localparam logic [31:0] IRQ_EN = 32'd0;
`endif

    logic        hb_clk;
    logic        hb_rst_n;
    logic [31:0] xt_hb_waddr;
    logic [31:0] xt_hb_raddr;
    logic [31:0] xt_hb_wdata;
    logic        sel_wen;
    logic        sel_ren;
    logic [31:0] rdata;
    logic        tx_irq;
    logic        uart_tx;

    int          checks;
    int          errors;
    vec_t        vecs[$];

    uart_tx_fifo_bus #(
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .hb_clk     (hb_clk),
        .hb_rst_n   (hb_rst_n),
        .xt_hb_waddr(xt_hb_waddr),
        .xt_hb_raddr(xt_hb_raddr),
        .xt_hb_wdata(xt_hb_wdata),
        .sel_wen    (sel_wen),
        .sel_ren    (sel_ren),
        .rdata      (rdata),
        .tx_irq     (tx_irq),
        .uart_tx    (uart_tx)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        hb_clk = 1'b0;
        forever #5 hb_clk = ~hb_clk;
    end

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                           input logic [31:0] ra, input logic [31:0] ex, input string nm);
        vec_t v;
        v.wr      = wr;
        v.waddr_v = wa;
        v.wdata_v = wd;
        v.raddr_v = ra;
        v.exp_v   = ex;
        v.name    = nm;
        vecs.push_back(v);
    endtask

    // Called on a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        xt_hb_waddr = addr;
        xt_hb_wdata = data;
        sel_wen     = 1'b1;
        @(negedge hb_clk);
        sel_wen     = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        xt_hb_raddr = addr;
        sel_ren     = 1'b1;
        @(negedge hb_clk);
        sel_ren     = 1'b0;
        data        = rdata;
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [31:0] d;
        if (v.wr) begin
            bus_write(v.waddr_v, v.wdata_v);
        end
        bus_read(v.raddr_v, d);
        check_output(v.name, d, v.exp_v);
    endtask

    // Compares one 8N1 frame cycle by cycle; reports the number of wrong cycles.
    task automatic check_frame(input logic [7:0] b, input int d, input string tag);
        int   bad;
        logic exp;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      exp = 1'b0;
            else if (k == 9) exp = 1'b1;
            else             exp = b[k-1];
            for (int c = 0; c < d; c++) begin
                @(negedge hb_clk);
                if (uart_tx !== exp) bad++;
            end
        end
        check_output(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_idle(input int n, input string tag);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge hb_clk);
            if (uart_tx !== 1'b1) bad++;
        end
        check_output(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        checks      = 0;
        errors      = 0;
        hb_rst_n    = 1'b0;
        sel_wen     = 1'b0;
        sel_ren     = 1'b0;
        xt_hb_waddr = 32'd0;
        xt_hb_raddr = 32'd0;
        xt_hb_wdata = 32'd0;

        add_vec(0, 32'h00, 32'h0,         32'h18, 32'h364,  "div_reset");
        add_vec(0, 32'h00, 32'h0,         32'h00, 32'h5,    "status_reset");
        add_vec(0, 32'h00, 32'h0,         32'h1C, 32'h5,    "status_at_28");
        add_vec(0, 32'h00, 32'h0,         32'h04, 32'h5,    "status_at_4");
        add_vec(1, 32'h18, 32'h1234,      32'h18, 32'h1234, "div_write");
        add_vec(1, 32'h18, 32'hABCD_0007, 32'h18, 32'h7,    "div_upper_ignored");
        add_vec(1, 32'h08, 32'h55,        32'h18, 32'h7,    "ignored_write_div");
        add_vec(1, 32'h10, 32'h99,        32'h10, 32'h5,    "ignored_write_status");
        add_vec(1, 32'h38, 32'h4,         32'h18, 32'h4,    "div_low_addr_decode");

        // Reset values while reset is held.
        repeat (3) @(negedge hb_clk);
        check_output("reset_uart_tx", 32'(uart_tx), 32'd1);
        check_output("reset_rdata", rdata, 32'd0);
        check_output("reset_tx_irq", 32'(tx_irq), 32'd0);
        hb_rst_n = 1'b1;
        @(negedge hb_clk);

        // Register map from the vector table.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
        end
        repeat (3) @(negedge hb_clk);
        check_output("rdata_hold", rdata, 32'd4);

        // Single 0xA5 frame at div=4, line low two edges after the write.
        fork
            begin
                check_idle(2, "a5_prestart");
                check_frame(8'hA5, 4, "a5_frame");
            end
            bus_write(32'h1C, 32'hA5);
        join
        bus_read(32'h00, d);
        check_output("a5_tx_done", d, 32'h5);

        // Three back-to-back frames with no idle gap, then the interrupt.
        fork
            begin
                check_idle(2, "b2b_prestart");
                for (int i = 0; i < 3; i++) begin
                    check_frame(8'(i + 1), 4, $sformatf("b2b_frame%0d", i));
                end
                check_output("b2b_irq_low_at_stop_end", 32'(tx_irq), 32'd0);
                @(negedge hb_clk);
                check_output("b2b_irq_rise", 32'(tx_irq), IRQ_EN);
            end
            begin
                sel_wen     = 1'b1;
                xt_hb_waddr = 32'h1C;
                for (int i = 0; i < 3; i++) begin
                    xt_hb_wdata = 32'(i + 1);
                    @(negedge hb_clk);
                end
                sel_wen = 1'b0;
            end
        join
        bus_read(32'h00, d);
        check_output("b2b_status", d, 32'h5);
        check_output("irq_hold_after_read", 32'(tx_irq), IRQ_EN);
        @(negedge hb_clk);
        check_output("irq_cleared", 32'(tx_irq), 32'd0);

        // Fill the FIFO behind an in-flight byte, then overflow with 0xFF.
        fork
            begin
                check_idle(2, "ovf_prestart");
                for (int i = 0; i < 9; i++) begin
                    check_frame(8'(8'h30 + i), 4, $sformatf("ovf_frame%0d", i));
                end
                check_idle(60, "ovf_ff_not_sent");
            end
            begin
                sel_wen     = 1'b1;
                xt_hb_waddr = 32'h1C;
                for (int i = 0; i < 9; i++) begin
                    xt_hb_wdata = 32'(8'h30 + i);
                    @(negedge hb_clk);
                end
                xt_hb_wdata = 32'hFF;
                @(negedge hb_clk);
                sel_wen = 1'b0;
                bus_read(32'h00, d);
                check_output("ovf_status_set", d, 32'h1A);
                bus_read(32'h00, d);
                check_output("ovf_status_cleared", d, 32'h0A);
            end
        join

        // Push while full on the very edge the stop bit ends: accepted, no overflow.
        fork
            begin
                check_idle(2, "fullpop_prestart");
                for (int i = 0; i < 9; i++) begin
                    check_frame(8'(8'hC0 + i), 4, $sformatf("fullpop_frame%0d", i));
                end
                check_frame(8'h7E, 4, "fullpop_extra_frame");
                check_idle(60, "fullpop_idle");
            end
            begin
                sel_wen     = 1'b1;
                xt_hb_waddr = 32'h1C;
                for (int i = 0; i < 9; i++) begin
                    xt_hb_wdata = 32'(8'hC0 + i);
                    @(negedge hb_clk);
                end
                sel_wen = 1'b0;
                repeat (32) @(negedge hb_clk);
                xt_hb_wdata = 32'h7E;
                sel_wen     = 1'b1;
                @(negedge hb_clk);
                sel_wen = 1'b0;
                bus_read(32'h00, d);
                check_output("fullpop_status", d, 32'h0A);
            end
        join

        // div=1 behaves as 2; a mid-frame write of 8 only affects the next frame.
        bus_write(32'h18, 32'h1);
        fork
            begin
                check_idle(2, "div_prestart");
                check_frame(8'h3C, 2, "div_min_frame");
                check_frame(8'hC3, 8, "div_next_frame");
                check_idle(20, "div_idle");
            end
            begin
                bus_write(32'h1C, 32'h3C);
                bus_write(32'h18, 32'h8);
                bus_write(32'h1C, 32'hC3);
            end
        join
        bus_read(32'h18, d);
        check_output("div_readback", d, 32'h8);

        // Asynchronous reset during the data bits with bytes still queued.
        bus_write(32'h18, 32'h4);
        sel_wen     = 1'b1;
        xt_hb_waddr = 32'h1C;
        xt_hb_wdata = 32'h5A;
        @(negedge hb_clk);
        xt_hb_wdata = 32'h11;
        @(negedge hb_clk);
        xt_hb_wdata = 32'h22;
        @(negedge hb_clk);
        sel_wen = 1'b0;
        repeat (13) @(negedge hb_clk);
        check_output("prereset_line_low", 32'(uart_tx), 32'd0);
        hb_rst_n = 1'b0;
        #1;
        check_output("midreset_uart_tx", 32'(uart_tx), 32'd1);
        check_output("midreset_rdata", rdata, 32'd0);
        check_output("midreset_tx_irq", 32'(tx_irq), 32'd0);
        @(negedge hb_clk);
        hb_rst_n = 1'b1;
        bus_read(32'h00, d);
        check_output("postreset_status", d, 32'h5);
        bus_read(32'h18, d);
        check_output("postreset_div", d, 32'h364);
        check_idle(100, "postreset_no_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
